// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B frame controller.
// Holds the controller state encoding, the GRB pixel width, and the
// default frame geometry (pixels per frame, latch-low length in clocks).
package ws2812b_pkg;

    localparam int PIX_W         = 24;
    localparam int DEF_LED_NUM   = 8;
    localparam int DEF_LATCH_CNT = 1620;   // 60 us at 27 MHz

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_LATCH = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/ws2812b_latch_timer.sv
// Latch-low delay counter.
//   clk    : clock
//   rst    : synchronous active-high reset
//   clear  : synchronous counter clear (wins over enable)
//   enable : count one clock
//   tc     : high on the LATCH_CNT-th enabled clock after clear
// The counter stops at LATCH_CNT, so tc cannot fire twice for one clear.
module ws2812b_latch_timer
    import ws2812b_pkg::*;
#(
    parameter int LATCH_CNT = DEF_LATCH_CNT,
    localparam int CNT_W    = $clog2(LATCH_CNT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(LATCH_CNT);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != CNT_TERM)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/ws2812b_frame_ctrl.sv
// WS2812B frame sequencer: reads LED_NUM GRB pixels from an external pixel
// memory and feeds them MSB-first, one bit at a time, to a bit encoder,
// then holds the line low for LATCH_CNT clocks and pulses frame_done.
//   Clock_27mhz : sole clock
//   rst         : synchronous active-high reset (aborts a frame at once)
//   start       : single-cycle frame request, honoured only when idle
//   pix_rd      : one-cycle read strobe, pix_addr = pixel index
//   pix_data    : GRB pixel, valid the clock after pix_rd
//   enc_en      : encoder enable, enc_bit = bit currently offered
//   enc_busy    : encoder busy flag
//   frame_busy  : high from the clock after an accepted start through done
//   frame_done  : one-cycle end-of-frame pulse
//   dbg_state   : current controller state (state_t encoding)
//
// Encoder handshake: while enc_en is high the offered bit on enc_bit is
// stable. The encoder takes the bit on the cycle its enc_busy rises (1 now,
// 0 the cycle before); the controller then advances to the next bit on the
// following clock. Rising edges of enc_busy while not sending are ignored.
module ws2812b_frame_ctrl
    import ws2812b_pkg::*;
#(
    parameter int LED_NUM   = DEF_LED_NUM,
    parameter int LATCH_CNT = DEF_LATCH_CNT,
    parameter int ADDR_W    = 8
) (
    input  logic              Clock_27mhz,
    input  logic              rst,
    input  logic              start,
    output logic              pix_rd,
    output logic [ADDR_W-1:0] pix_addr,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              enc_en,
    output logic              enc_bit,
    input  logic              enc_busy,
    output logic              frame_busy,
    output logic              frame_done,
    output logic [2:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LED_NUM - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  pix_idx;
    logic [PIX_W-1:0]   shift_q;
    logic [4:0]         bit_cnt;
    logic               busy_q;
    logic               accept;
    logic               last_bit;
    logic               last_pix;
    logic               lt_clear;
    logic               lt_en;
    logic               lt_tc;

    assign accept   = (state == ST_SEND) && enc_busy && !busy_q;
    assign last_bit = (bit_cnt == 5'd23);
    assign last_pix = (pix_idx == LAST_IDX);

    // State register
    always_ff @(posedge Clock_27mhz) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SEND;
            ST_SEND:  if (accept && last_bit) state_nxt = last_pix ? ST_DRAIN : ST_FETCH;
            ST_DRAIN: if (!enc_busy) state_nxt = ST_LATCH;
            ST_LATCH: if (lt_tc) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pix_rd     = 1'b0;
        enc_en     = 1'b0;
        enc_bit    = 1'b0;
        frame_busy = (state != ST_IDLE);
        frame_done = 1'b0;
        lt_clear   = 1'b0;
        lt_en      = 1'b0;
        case (state)
            ST_FETCH: pix_rd = 1'b1;
            ST_SEND: begin
                enc_en  = 1'b1;
                enc_bit = shift_q[PIX_W-1];
            end
            ST_DRAIN: lt_clear = 1'b1;
            ST_LATCH: lt_en    = 1'b1;
            ST_DONE:  frame_done = 1'b1;
            default: ;
        endcase
    end

    assign pix_addr  = pix_idx;
    assign dbg_state = state;

    // Datapath: pixel index, shift register, bit counter, busy edge history
    always_ff @(posedge Clock_27mhz) begin
        if (rst) begin
            pix_idx <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b0;
        end else begin
            busy_q <= enc_busy;
            case (state)
                ST_IDLE: if (start) pix_idx <= '0;
                ST_LOAD: begin
                    shift_q <= pix_data;
                    bit_cnt <= '0;
                end
                ST_SEND: if (accept) begin
                    shift_q <= {shift_q[PIX_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    // index stops at the last pixel; never wraps
                    if (last_bit && !last_pix) pix_idx <= pix_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    ws2812b_latch_timer #(
        .LATCH_CNT(LATCH_CNT)
    ) u_latch_timer (
        .clk    (Clock_27mhz),
        .rst    (rst),
        .clear  (lt_clear),
        .enable (lt_en),
        .tc     (lt_tc)
    );

endmodule

// File: tb/tb_ws2812b_frame_ctrl.sv
// Bench for ws2812b_frame_ctrl: one 2-pixel and one 1-pixel instance share a
// single encoder model and pixel memory, selected by sel. A frame-level model
// (queues of expected addresses and bits, event-scheduled timing) is checked
// against the selected instance on every negative clock edge.
module tb_ws2812b_frame_ctrl;

    localparam int LATCH = 1620;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        spur;
    logic        sel;
    logic [23:0] pix_data;
    logic [23:0] pix_val [0:1];

    logic       a_rd, a_en, a_bit, a_fb, a_fd, a_start, a_busy;
    logic [7:0] a_addr;
    logic [2:0] a_st;
    logic       b_rd, b_en, b_bit, b_fb, b_fd, b_start, b_busy;
    logic [7:0] b_addr;
    logic [2:0] b_st;

    logic       enc_busy, enc_model_busy;
    int         enc_hold;

    logic       m_rd, m_en, m_bit, m_fb, m_fd;
    logic [7:0] m_addr;

    assign a_start  = start & ~sel;
    assign b_start  = start & sel;
    assign enc_busy = enc_model_busy | spur;
    assign a_busy   = enc_busy & ~sel;
    assign b_busy   = enc_busy & sel;
    assign m_rd     = sel ? b_rd   : a_rd;
    assign m_en     = sel ? b_en   : a_en;
    assign m_bit    = sel ? b_bit  : a_bit;
    assign m_fb     = sel ? b_fb   : a_fb;
    assign m_fd     = sel ? b_fd   : a_fd;
    assign m_addr   = sel ? b_addr : a_addr;

    ws2812b_frame_ctrl #(.LED_NUM(2), .LATCH_CNT(LATCH), .ADDR_W(8)) dut_a (
        .Clock_27mhz(clk), .rst(rst), .start(a_start),
        .pix_rd(a_rd), .pix_addr(a_addr), .pix_data(pix_data),
        .enc_en(a_en), .enc_bit(a_bit), .enc_busy(a_busy),
        .frame_busy(a_fb), .frame_done(a_fd), .dbg_state(a_st)
    );

    ws2812b_frame_ctrl #(.LED_NUM(1), .LATCH_CNT(LATCH), .ADDR_W(8)) dut_b (
        .Clock_27mhz(clk), .rst(rst), .start(b_start),
        .pix_rd(b_rd), .pix_addr(b_addr), .pix_data(pix_data),
        .enc_en(b_en), .enc_bit(b_bit), .enc_busy(b_busy),
        .frame_busy(b_fb), .frame_done(b_fd), .dbg_state(b_st)
    );

    // Pixel memory: data valid the clock after the read strobe.
    always @(posedge clk) begin
        if (m_rd) pix_data <= pix_val[m_addr[0]];
    end

    // Encoder model: busy rises one clock after enable is seen, stays high
    // 5 clocks, then drops for at least one clock.
    always @(posedge clk) begin
        if (rst) begin
            enc_model_busy <= 1'b0;
            enc_hold       <= 0;
        end else if (enc_model_busy) begin
            if (enc_hold == 0) enc_model_busy <= 1'b0;
            else enc_hold <= enc_hold - 1;
        end else if (m_en) begin
            enc_model_busy <= 1'b1;
            enc_hold       <= 4;
        end
    end

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [0:0] exp_q [$];
    logic [7:0] addr_q [$];

    bit          md_act = 1'b0;
    int          md_fetch_at = -1;
    int          md_send_from = -1;
    int          md_done_at = -1;
    bit          md_wait_fall = 1'b0;
    int          md_bit_in_pix = 0;
    int          fall_cyc = 0;
    bit          rst_prev = 1'b0;
    bit          busy_prev = 1'b0;

    int          n_rd, n_acc, n_done, fall_to_done;
    logic [47:0] got_bits;

    task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        bit was_act;
        bit rd_exp;
        bit en_exp;
        bit acc;
        int npix;
        cyc++;
        was_act = md_act;

        if (rst_prev) begin
            chk("rst_pix_rd", m_rd, 0);
            chk("rst_pix_addr", m_addr, 0);
            chk("rst_enc_en", m_en, 0);
            chk("rst_enc_bit", m_bit, 0);
            chk("rst_frame_busy", m_fb, 0);
            chk("rst_frame_done", m_fd, 0);
        end

        rd_exp = md_act && (cyc == md_fetch_at);
        en_exp = md_act && (md_send_from >= 0) && (cyc >= md_send_from);

        chk("pix_rd", m_rd, rd_exp);
        if (rd_exp) begin
            n_rd++;
            if (addr_q.size() > 0) chk("pix_addr", m_addr, addr_q.pop_front());
            else fail_msg("pix_addr_unexpected");
            md_send_from = cyc + 2;
        end

        chk("enc_en", m_en, en_exp);
        if (en_exp && exp_q.size() > 0) chk("enc_bit", m_bit, exp_q[0]);

        acc = en_exp && enc_busy && !busy_prev;
        if (acc) begin
            n_acc++;
            got_bits = {got_bits[46:0], m_bit};
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            else fail_msg("extra_bit_accepted");
            md_bit_in_pix++;
            if (md_bit_in_pix == 24) begin
                md_bit_in_pix = 0;
                md_send_from  = -1;
                if (addr_q.size() > 0) md_fetch_at = cyc + 1;
                else md_wait_fall = 1'b1;
            end
        end

        if (md_wait_fall && !acc && !enc_busy) begin
            fall_cyc     = cyc;
            md_done_at   = cyc + 1 + LATCH;
            md_wait_fall = 1'b0;
        end

        chk("frame_busy", m_fb, md_act);
        chk("frame_done", m_fd, md_act && (cyc == md_done_at));
        if (md_act && (cyc == md_done_at)) begin
            n_done++;
            fall_to_done = cyc - fall_cyc;
            chk("bits_left_at_done", exp_q.size(), 0);
            md_act     = 1'b0;
            md_done_at = -1;
        end

        if (start && !was_act && !rst) begin
            npix = sel ? 1 : 2;
            md_act        = 1'b1;
            md_fetch_at   = cyc + 1;
            md_send_from  = -1;
            md_bit_in_pix = 0;
            for (int p = 0; p < npix; p++) begin
                addr_q.push_back(8'(p));
                for (int b = 23; b >= 0; b--) exp_q.push_back(pix_val[p][b]);
            end
        end

        if (rst) begin
            md_act        = 1'b0;
            md_fetch_at   = -1;
            md_send_from  = -1;
            md_done_at    = -1;
            md_wait_fall  = 1'b0;
            md_bit_in_pix = 0;
            exp_q.delete();
            addr_q.delete();
        end

        rst_prev  = rst;
        busy_prev = enc_busy;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_spur();
        spur = 1'b1;
        tick();
        spur = 1'b0;
    endtask

    task automatic clear_stats();
        n_rd = 0;
        n_acc = 0;
        n_done = 0;
        fall_to_done = 0;
        got_bits = '0;
    endtask

    task automatic wait_done(input string name);
        int n0;
        n0 = n_done;
        for (int i = 0; i < 6000 && n_done == n0; i++) tick();
        if (n_done == n0) fail_msg(name);
    endtask

    task automatic wait_acc(input int k, input string name);
        for (int i = 0; i < 2000 && n_acc < k; i++) tick();
        if (n_acc < k) fail_msg(name);
    endtask

    task automatic wait_latch(input string name);
        for (int i = 0; i < 2000 && !(md_done_at >= 0 && cyc > fall_cyc + 20); i++) tick();
        if (!(md_done_at >= 0 && cyc > fall_cyc + 20)) fail_msg(name);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        spur  = 1'b0;
        sel   = 1'b0;
        pix_val[0] = 24'hFF0000;
        pix_val[1] = 24'h00A5C3;
        clear_stats();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_state_a", a_st, 0);
        chk("reset_state_b", b_st, 0);
        chk("reset_busy_a", a_fb, 0);

        // spurious busy pulse while idle: nothing happens
        pulse_spur();
        repeat (3) tick();
        chk("idle_spur_state", a_st, 0);
        chk("idle_spur_acc", n_acc, 0);

        // 2-pixel frame with ignored start in SEND and LATCH, spur in LATCH
        clear_stats();
        pulse_start();
        wait_acc(5, "timeout_acc5");
        pulse_start();
        wait_latch("timeout_latch1");
        pulse_start();
        repeat (10) tick();
        pulse_spur();
        wait_done("timeout_done1");
        repeat (2) tick();
        chk("f1_bits", got_bits, 48'hFF0000_00A5C3);
        chk("f1_acc_count", n_acc, 48);
        chk("f1_rd_count", n_rd, 2);
        chk("f1_done_count", n_done, 1);
        chk("f1_fall_to_done", fall_to_done, LATCH + 1);
        chk("f1_busy_after", a_fb, 0);

        // reset during bit 10 of pixel 1, then a clean restart
        clear_stats();
        pulse_start();
        wait_acc(34, "timeout_acc34");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("abort_done_count", n_done, 0);
        chk("abort_state", a_st, 0);
        clear_stats();
        pulse_start();
        wait_done("timeout_done2");
        repeat (2) tick();
        chk("f2_bits", got_bits, 48'hFF0000_00A5C3);
        chk("f2_rd_count", n_rd, 2);
        chk("f2_done_count", n_done, 1);

        // single-pixel instance
        sel = 1'b1;
        pix_val[0] = 24'h800001;
        tick();
        clear_stats();
        pulse_start();
        wait_done("timeout_done3");
        repeat (2) tick();
        chk("f3_bits", got_bits[23:0], 24'h800001);
        chk("f3_acc_count", n_acc, 24);
        chk("f3_rd_count", n_rd, 1);
        chk("f3_done_count", n_done, 1);
        chk("f3_fall_to_done", fall_to_done, LATCH + 1);
        chk("f3_busy_after", b_fb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
